// File: rtl/otter_rf_pkg.sv
// ============================================================================
// Module   : otter_rf_pkg
// Brief    : Shared widths and the register-file write record.
// Revision : 1.0
// ============================================================================
`default_nettype none

package otter_rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_t;
endpackage

`default_nettype wire

// File: rtl/rf_wr_fifo.sv
// ============================================================================
// Module   : rf_wr_fifo
// Brief    : Synchronous FIFO of register-file write records.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_wr_fifo
  import otter_rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic   CLK,
  input  logic   RST_N,
  input  logic   i_push,
  input  rf_wr_t i_data,
  input  logic   i_pop,
  output logic   o_full,
  output logic   o_empty,
  output rf_wr_t o_head
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

  rf_wr_t               r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_write_scheduler.sv
// ============================================================================
// Module   : rf_write_scheduler
// Brief    : Register-file write-port arbiter (WB vs long-latency FIFO) with
//            starvation stall and per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_write_scheduler
  import otter_rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WB_WE,
  input  logic [REG_ADDR_W-1:0] WB_A3,
  input  logic [XLEN-1:0]       WB_WD3,
  input  logic                  LL_VALID,
  output logic                  LL_READY,
  input  logic [REG_ADDR_W-1:0] LL_A3,
  input  logic [XLEN-1:0]       LL_WD3,
  input  logic                  ISSUE_VALID,
  input  logic [REG_ADDR_W-1:0] ISSUE_RD,
  output logic                  ISSUE_STALL,
  input  logic [REG_ADDR_W-1:0] DEC_A1,
  input  logic [REG_ADDR_W-1:0] DEC_A2,
  output logic                  DEC_BUSY,
  output logic                  PIPE_STALL,
  output logic                  RF_WE,
  output logic [REG_ADDR_W-1:0] RF_A3,
  output logic [XLEN-1:0]       RF_WD3,
  output logic [NUM_REGS-1:0]   BUSY_VEC
);

  localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                r_pipe_stall;
  logic [c_CNT_W-1:0]  r_starve_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_set;
  logic [NUM_REGS-1:0] w_busy_clr;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  rf_wr_t              w_head;
  rf_wr_t              w_push_data;
  logic                w_push;
  logic                w_wb_req;
  logic                w_head_grant;
  logic                w_issue_ok;

  assign w_push_data = '{addr: LL_A3, data: LL_WD3};
  assign LL_READY    = RST_N & ~w_fifo_full;
  assign w_push      = LL_VALID & LL_READY;

  rf_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_head_grant),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head)
  );

  // WB has priority unless the pipeline is frozen to drain a starved head.
  assign w_wb_req     = RST_N & WB_WE & (WB_A3 != '0) & ~r_pipe_stall;
  assign w_head_grant = RST_N & ~w_wb_req & ~w_fifo_empty;

  always_comb begin
    RF_WE  = 1'b0;
    RF_A3  = '0;
    RF_WD3 = '0;
    if (w_wb_req) begin
      RF_WE  = 1'b1;
      RF_A3  = WB_A3;
      RF_WD3 = WB_WD3;
    end else if (w_head_grant) begin
      RF_WE  = (w_head.addr != '0);
      RF_A3  = w_head.addr;
      RF_WD3 = w_head.data;
    end
  end

  // Stall is raised on the edge where the denial count reaches the limit.
  assign w_cnt_nxt = r_starve_cnt + c_CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_starve_cnt <= '0;
      r_pipe_stall <= 1'b0;
    end else if (r_pipe_stall) begin
      r_starve_cnt <= '0;
      r_pipe_stall <= 1'b0;
    end else if (!w_fifo_empty && !w_head_grant) begin
      r_starve_cnt <= w_cnt_nxt;
      r_pipe_stall <= (w_cnt_nxt == c_CNT_W'(STARVE_LIMIT));
    end else begin
      r_starve_cnt <= '0;
      r_pipe_stall <= 1'b0;
    end
  end

  assign PIPE_STALL  = r_pipe_stall;
  assign ISSUE_STALL = ISSUE_VALID & (ISSUE_RD != '0) & r_busy[ISSUE_RD];
  assign w_issue_ok  = ISSUE_VALID & (ISSUE_RD != '0) & ~r_busy[ISSUE_RD];
  assign DEC_BUSY    = ((DEC_A1 != '0) & r_busy[DEC_A1]) |
                       ((DEC_A2 != '0) & r_busy[DEC_A2]);

  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (w_issue_ok)   w_busy_set[ISSUE_RD]    = 1'b1;
    if (w_head_grant) w_busy_clr[w_head.addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~NUM_REGS'(1);
    end
  end

  assign BUSY_VEC = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_scheduler.sv
// ============================================================================
// Module   : tb_rf_write_scheduler
// Brief    : Directed + randomized bench against a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rf_write_scheduler;
  import otter_rf_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        WB_WE;
  logic [4:0]  WB_A3;
  logic [31:0] WB_WD3;
  logic        LL_VALID;
  logic        LL_READY;
  logic [4:0]  LL_A3;
  logic [31:0] LL_WD3;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_RD;
  logic        ISSUE_STALL;
  logic [4:0]  DEC_A1;
  logic [4:0]  DEC_A2;
  logic        DEC_BUSY;
  logic        PIPE_STALL;
  logic        RF_WE;
  logic [4:0]  RF_A3;
  logic [31:0] RF_WD3;
  logic [31:0] BUSY_VEC;

  int checks = 0;
  int errors = 0;

  rf_wr_t      mq[$];
  logic [31:0] m_busy = '0;
  int          m_wait = 0;
  bit          m_stall = 1'b0;
  bit          ll_taken = 1'b0;

  always #5 CLK = ~CLK;

  rf_write_scheduler dut (
    .CLK(CLK), .RST_N(RST_N),
    .WB_WE(WB_WE), .WB_A3(WB_A3), .WB_WD3(WB_WD3),
    .LL_VALID(LL_VALID), .LL_READY(LL_READY), .LL_A3(LL_A3), .LL_WD3(LL_WD3),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .ISSUE_STALL(ISSUE_STALL),
    .DEC_A1(DEC_A1), .DEC_A2(DEC_A2), .DEC_BUSY(DEC_BUSY),
    .PIPE_STALL(PIPE_STALL),
    .RF_WE(RF_WE), .RF_A3(RF_A3), .RF_WD3(RF_WD3),
    .BUSY_VEC(BUSY_VEC)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    WB_WE = 0; WB_A3 = 0; WB_WD3 = 0;
    LL_VALID = 0; LL_A3 = 0; LL_WD3 = 0;
    ISSUE_VALID = 0; ISSUE_RD = 0; DEC_A1 = 0; DEC_A2 = 0;
  endtask

  // Compare every output mid-cycle against the model, then advance the model over the edge.
  task automatic step();
    int          sz;
    bit          wb_req, granted, e_we, e_ready, e_istall, e_dbusy, issue_acc;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    #4;
    sz       = mq.size();
    e_ready  = RST_N && (sz < 4);
    wb_req   = RST_N && WB_WE && (WB_A3 != 0) && !m_stall;
    granted  = RST_N && !wb_req && (sz > 0);
    e_we = 0; e_a3 = 0; e_wd = 0;
    if (wb_req) begin
      e_we = 1; e_a3 = WB_A3; e_wd = WB_WD3;
    end else if (granted) begin
      e_we = (mq[0].addr != 0); e_a3 = mq[0].addr; e_wd = mq[0].data;
    end
    e_istall  = ISSUE_VALID && (ISSUE_RD != 0) && m_busy[ISSUE_RD];
    issue_acc = ISSUE_VALID && (ISSUE_RD != 0) && !m_busy[ISSUE_RD];
    e_dbusy   = ((DEC_A1 != 0) && m_busy[DEC_A1]) || ((DEC_A2 != 0) && m_busy[DEC_A2]);

    check("RF_WE", 32'(RF_WE), 32'(e_we));
    if (e_we) begin
      check("RF_A3", 32'(RF_A3), 32'(e_a3));
      check("RF_WD3", RF_WD3, e_wd);
    end
    check("LL_READY", 32'(LL_READY), 32'(e_ready));
    check("PIPE_STALL", 32'(PIPE_STALL), 32'(m_stall));
    check("BUSY_VEC", BUSY_VEC, m_busy);
    check("ISSUE_STALL", 32'(ISSUE_STALL), 32'(e_istall));
    check("DEC_BUSY", 32'(DEC_BUSY), 32'(e_dbusy));

    ll_taken = LL_VALID && e_ready;
    if (!RST_N) begin
      mq.delete(); m_busy = '0; m_wait = 0; m_stall = 0;
    end else begin
      if (m_stall) begin
        m_stall = 0; m_wait = 0;
      end else if (sz > 0 && !granted) begin
        m_wait++;
        if (m_wait == 8) m_stall = 1;
      end else begin
        m_wait = 0;
      end
      if (granted) begin
        m_busy[mq[0].addr] = 1'b0;
        void'(mq.pop_front());
      end
      if (issue_acc) m_busy[ISSUE_RD] = 1'b1;
      if (ll_taken) mq.push_back({LL_A3, LL_WD3});
      m_busy[0] = 1'b0;
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int k;
    idle();
    // Reset with requests asserted
    RST_N = 0; WB_WE = 1; WB_A3 = 5; LL_VALID = 1; LL_A3 = 4;
    @(posedge CLK); #1;
    step();
    RST_N = 1; idle();
    step();

    // WB write goes straight through; x0 is suppressed
    WB_WE = 1; WB_A3 = 5; WB_WD3 = 32'hDEADBEEF;
    #1; check("t2_wd3", RF_WD3, 32'hDEADBEEF);
    step();
    WB_A3 = 0;
    step();
    idle();

    // Issue x7, decode sees it busy, LL result clears it
    ISSUE_VALID = 1; ISSUE_RD = 7;
    step();
    ISSUE_VALID = 0; DEC_A1 = 7;
    #1; check("t3_dec_busy", 32'(DEC_BUSY), 32'd1);
    step();
    LL_VALID = 1; LL_A3 = 7; LL_WD3 = 32'h1234;
    step();
    LL_VALID = 0;
    #1; check("t3_rf_a3", 32'(RF_A3), 32'd7);
    step();
    check("t3_busy7", 32'(BUSY_VEC[7]), 32'd0);
    step();

    // Starvation: WB saturates, head forced out on the 9th cycle
    idle();
    WB_WE = 1; WB_A3 = 9; WB_WD3 = 32'h99;
    LL_VALID = 1; LL_A3 = 12; LL_WD3 = 32'hC0FFEE;
    step();
    LL_VALID = 0;
    k = 1;
    while (!PIPE_STALL && k < 20) begin
      step();
      k++;
    end
    check("t4_stall_cycle", 32'(k), 32'd9);
    check("t4_stall_a3", 32'(RF_A3), 32'd12);
    step();
    check("t4_stall_clear", 32'(PIPE_STALL), 32'd0);

    // Five LL results under saturating WB: back-pressure, none lost, in order
    for (int n = 0; n < 5; n++) begin
      LL_VALID = 1; LL_A3 = 5'(n + 11); LL_WD3 = 32'hA0 + 32'(n);
      k = 0;
      do begin
        step();
        k++;
      end while (!ll_taken && k < 60);
      check("t5_accepted", 32'(ll_taken), 32'd1);
    end
    idle();
    k = 0;
    while (mq.size() != 0 && k < 20) begin
      step();
      k++;
    end
    check("t5_drained", 32'(mq.size()), 32'd0);

    // Duplicate issue stalls; issue to x0 never stalls
    ISSUE_VALID = 1; ISSUE_RD = 3;
    step();
    #1; check("t6_istall", 32'(ISSUE_STALL), 32'd1);
    step();
    ISSUE_RD = 0;
    step();
    check("t6_busy0", 32'(BUSY_VEC[0]), 32'd0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      int wb_pct;
      wb_pct = (i < 250) ? 95 : 55;
      RST_N  = !(i == 400 || i == 401);
      WB_WE  = ($urandom_range(0, 99) < wb_pct);
      WB_A3  = 5'($urandom_range(0, 31));
      WB_WD3 = $urandom;
      if (!LL_VALID || ll_taken) begin
        LL_VALID = ($urandom_range(0, 2) == 0);
        LL_A3    = 5'($urandom_range(0, 31));
        LL_WD3   = $urandom;
      end
      ISSUE_VALID = ($urandom_range(0, 2) == 0);
      ISSUE_RD    = 5'($urandom_range(0, 31));
      DEC_A1      = 5'($urandom_range(0, 31));
      DEC_A2      = 5'($urandom_range(0, 31));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
